// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM data-port OBI arbiter.
// in_window() decides whether a byte address falls inside the SRAM window.
package sram_pkg;

    localparam logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000;
    localparam int unsigned SRAM_SIZE_BYTES = 32768;
    localparam logic [31:0] SRAM_ERR_RDATA  = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } rsp_track_t;

    // The offset compare alone would wrap for addresses below base, so both checks are needed.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned size);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < size);
    endfunction

endpackage

// File: rtl/sram_d_obi_arb_if.sv
// OBI request/response bundle used for both arbiter masters and the SRAM data port.
// The master modport drives the request side; the slave modport answers.
interface sram_d_obi_arb_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the priority pointer flips away from whoever
// completed a handshake and holds otherwise.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       ack_i,
    output logic       gnt_idx_o,
    output logic       gnt_valid_o
);

    logic prio_q;

    always_comb begin
        gnt_valid_o = |req_i;
        if (&req_i) begin
            gnt_idx_o = prio_q;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (ack_i) begin
            prio_q <= ~gnt_idx_o;
        end
    end

endmodule

// File: rtl/sram_d_obi_arb.sv
// Two-master OBI arbiter in front of the SRAM data port: round-robin pick, window check
// with local error responses, and 1-cycle response routing back to the granted master.
module sram_d_obi_arb
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR,
    parameter int unsigned SIZE_BYTES = SRAM_SIZE_BYTES,
    parameter logic [31:0] ERR_RDATA  = SRAM_ERR_RDATA
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sram_d_obi_arb_if.slave   m0_io,
    sram_d_obi_arb_if.slave   m1_io,
    sram_d_obi_arb_if.master  s_io
);

    // Holds all request paths off until the first clock after reset release.
    logic       active_q;
    obi_req_t   req_pl [2];
    logic [1:0] req_vec;
    logic [1:0] legal_vec;
    logic       win_idx;
    logic       win_valid;
    logic       win_legal;
    obi_req_t   win_pl;
    obi_req_t   s_pl;
    logic       s_req;
    logic       granted;
    logic [1:0] gnt_vec;
    rsp_track_t rsp_q;
    rsp_track_t rsp_d;
    obi_rsp_t   rsp [2];
    logic       unused_s_err;

    assign unused_s_err = s_io.err;

    always_comb begin
        req_pl[0].addr  = m0_io.addr;
        req_pl[0].we    = m0_io.we;
        req_pl[0].be    = m0_io.be;
        req_pl[0].wdata = m0_io.wdata;
        req_pl[1].addr  = m1_io.addr;
        req_pl[1].we    = m1_io.we;
        req_pl[1].be    = m1_io.be;
        req_pl[1].wdata = m1_io.wdata;
        req_vec         = {m1_io.req, m0_io.req} & {2{active_q}};
        for (int i = 0; i < 2; i++) begin
            legal_vec[i] = in_window(req_pl[i].addr, BASE_ADDR, SIZE_BYTES);
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_vec),
        .ack_i       (granted),
        .gnt_idx_o   (win_idx),
        .gnt_valid_o (win_valid)
    );

    // Out-of-window winners are granted locally and never see the SRAM.
    always_comb begin
        win_pl    = req_pl[win_idx];
        win_legal = legal_vec[win_idx];
        s_req     = win_valid && win_legal;
        s_pl      = s_req ? win_pl : '0;
        granted   = win_valid && (win_legal ? s_io.gnt : 1'b1);
        gnt_vec   = granted ? (win_idx ? 2'b10 : 2'b01) : 2'b00;

        s_io.req   = s_req;
        s_io.addr  = s_pl.addr;
        s_io.we    = s_pl.we;
        s_io.be    = s_pl.be;
        s_io.wdata = s_pl.wdata;

        m0_io.gnt  = gnt_vec[0];
        m1_io.gnt  = gnt_vec[1];
    end

    always_comb begin
        rsp_d = '0;
        if (granted) begin
            rsp_d.valid = 1'b1;
            rsp_d.owner = win_idx;
            rsp_d.err   = ~win_legal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            active_q <= 1'b1;
            rsp_q    <= rsp_d;
        end
    end

    // SRAM responses outside a tracked legal slot are dropped here.
    always_comb begin
        rsp[0] = '0;
        rsp[1] = '0;
        if (rsp_q.valid) begin
            if (rsp_q.err) begin
                rsp[rsp_q.owner].rvalid = 1'b1;
                rsp[rsp_q.owner].rdata  = ERR_RDATA;
                rsp[rsp_q.owner].err    = 1'b1;
            end else begin
                rsp[rsp_q.owner].rvalid = s_io.rvalid;
                rsp[rsp_q.owner].rdata  = s_io.rdata;
                rsp[rsp_q.owner].err    = 1'b0;
            end
        end

        m0_io.rvalid = rsp[0].rvalid;
        m0_io.rdata  = rsp[0].rdata;
        m0_io.err    = rsp[0].err;
        m1_io.rvalid = rsp[1].rvalid;
        m1_io.rdata  = rsp[1].rdata;
        m1_io.err    = rsp[1].err;
    end

endmodule

// File: tb/tb_sram_d_obi_arb.sv
// Bench for sram_d_obi_arb: hand-computed vector table, directed corner sequences and a
// randomized run checked against a transaction-level model with its own memory image.
module tb_sram_d_obi_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_d_obi_arb_if m0_if ();
    sram_d_obi_arb_if m1_if ();
    sram_d_obi_arb_if s_if ();

    sram_d_obi_arb dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0_io  (m0_if),
        .m1_io  (m1_if),
        .s_io   (s_if)
    );

    // SRAM stand-in: pre-zeroed, byte-enabled writes, one-cycle read latency.
    logic [31:0] sram_mem [8192];
    initial for (int i = 0; i < 8192; i++) sram_mem[i] = '0;

    always @(posedge clk) begin
        s_if.rvalid <= s_if.req && s_if.gnt;
        s_if.rdata  <= '0;
        if (s_if.req && s_if.gnt) begin
            if (s_if.we) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_if.be[b]) sram_mem[s_if.addr[14:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];
                end
            end else begin
                s_if.rdata <= sram_mem[s_if.addr[14:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.req = req; m0_if.addr = addr; m0_if.we = we; m0_if.be = be; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.addr = addr; m1_if.we = we; m1_if.be = be; m1_if.wdata = wdata;
        end
    endtask

    task automatic idle();
        set_m(0, 1'b0, 32'h8000_0000, 1'b0, 4'hF, '0);
        set_m(1, 1'b0, 32'h8000_0004, 1'b0, 4'hF, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        s_if.gnt = 1'b1;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // ---------------- transaction-level reference model ----------------
    int           last_win;
    bit           pend_v;
    int           pend_own;
    bit           pend_err;
    logic [31:0]  pend_rdata;
    logic [31:0]  shadow [int unsigned];

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned x;
        x = a;
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'd32768);
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a >> 2) ? shadow[a >> 2] : 32'h0;
    endfunction

    task automatic model_reset();
        last_win = 1;
        pend_v   = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0]  r;
        int          w;
        bit          lg;
        logic [31:0] a, wd, old, mask;
        logic        we;
        logic [3:0]  be;
        chk("rnd_rvalid0", m0_if.rvalid, pend_v && pend_own == 0);
        chk("rnd_rvalid1", m1_if.rvalid, pend_v && pend_own == 1);
        chk("rnd_rdata0", m0_if.rdata, (pend_v && pend_own == 0) ? pend_rdata : 32'h0);
        chk("rnd_rdata1", m1_if.rdata, (pend_v && pend_own == 1) ? pend_rdata : 32'h0);
        chk("rnd_err0", m0_if.rvalid & m0_if.err, pend_v && pend_own == 0 && pend_err);
        chk("rnd_err1", m1_if.rvalid & m1_if.err, pend_v && pend_own == 1 && pend_err);
        r = {m1_if.req, m0_if.req};
        w = -1;
        if (r == 2'b11) w = 1 - last_win;
        else if (r[0]) w = 0;
        else if (r[1]) w = 1;
        if (w < 0) begin
            chk("rnd_gnt0", m0_if.gnt, 1'b0);
            chk("rnd_gnt1", m1_if.gnt, 1'b0);
            chk("rnd_sreq", s_if.req, 1'b0);
            pend_v = 1'b0;
            return;
        end
        a  = (w == 1) ? m1_if.addr : m0_if.addr;
        we = (w == 1) ? m1_if.we : m0_if.we;
        be = (w == 1) ? m1_if.be : m0_if.be;
        wd = (w == 1) ? m1_if.wdata : m0_if.wdata;
        lg = in_win(a);
        chk("rnd_sreq", s_if.req, lg);
        if (lg) chk("rnd_saddr", s_if.addr, a);
        chk("rnd_gnt0", m0_if.gnt, (w == 0) && (!lg || s_if.gnt));
        chk("rnd_gnt1", m1_if.gnt, (w == 1) && (!lg || s_if.gnt));
        if (!lg || s_if.gnt) begin
            last_win   = w;
            pend_v     = 1'b1;
            pend_own   = w;
            pend_err   = !lg;
            pend_rdata = !lg ? 32'hDEAD_BEEF : (we ? 32'h0 : shadow_rd(a));
            if (lg && we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                old  = shadow_rd(a);
                shadow[a >> 2] = (old & ~mask) | (wd & mask);
            end
        end else begin
            pend_v = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 32'h7FFF_FFFC;
            1: return 32'h8000_8000;
            2: return 32'h8000_7FFC;
            3: return 32'hFFFF_FFFC;
            default: return 32'h8000_0000 + 4 * $urandom_range(0, 15);
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        r0, r1;
        logic [31:0] a0, a1;
        logic        sg;
        logic        eg0, eg1, esreq, erv0, erv1, eerr0, eerr1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        s_if.err = 1'b0;
        s_if.gnt = 1'b1;
        rst_n    = 1'b0;
        idle();

        // Reset with both masters requesting: everything quiet, m0 wins first after release.
        set_m(0, 1'b1, 32'h8000_0000, 1'b0, 4'hF, '0);
        set_m(1, 1'b1, 32'h8000_0004, 1'b0, 4'hF, '0);
        repeat (2) @(negedge clk);
        chk("rst_gnt0", m0_if.gnt, 1'b0);
        chk("rst_gnt1", m1_if.gnt, 1'b0);
        chk("rst_rvalid0", m0_if.rvalid, 1'b0);
        chk("rst_rvalid1", m1_if.rvalid, 1'b0);
        chk("rst_sreq", s_if.req, 1'b0);
        chk("rst_saddr", s_if.addr, 32'h0);
        chk("rst_rdata0", m0_if.rdata, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            @(negedge clk);
            if (m0_if.gnt || m1_if.gnt) begin
                got = 1'b1;
                chk("rst_first_gnt0", m0_if.gnt, 1'b1);
                chk("rst_first_gnt1", m1_if.gnt, 1'b0);
            end
            next_cycle();
        end
        if (!got) chk("rst_first_gnt_seen", 1'b0, 1'b1);

        // Hand-computed arbitration/response table, applied from a fresh reset.
        tbl[0] = '{1, 1, 32'h8000_0000, 32'h8000_0004, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 32'h8000_0000, 32'h8000_0004, 1, 0, 1, 1, 1, 0, 0, 0};
        tbl[2] = '{0, 1, 32'h8000_0000, 32'h8000_0004, 1, 0, 1, 1, 0, 1, 0, 0};
        tbl[3] = '{1, 1, 32'h8000_0000, 32'h8000_0004, 1, 1, 0, 1, 0, 1, 0, 0};
        tbl[4] = '{1, 0, 32'h7FFF_FFFC, 32'h8000_0004, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{1, 1, 32'h8000_0000, 32'h8000_0004, 0, 0, 0, 1, 1, 0, 1, 0};
        tbl[6] = '{1, 1, 32'h8000_0000, 32'h8000_0004, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 32'h8000_0000, 32'h8000_0004, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[8] = '{0, 1, 32'h8000_0000, 32'h8000_8000, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[9] = '{0, 0, 32'h8000_0000, 32'h8000_0004, 1, 0, 0, 0, 0, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_m(0, tbl[i].r0, tbl[i].a0, 1'b0, 4'hF, '0);
            set_m(1, tbl[i].r1, tbl[i].a1, 1'b0, 4'hF, '0);
            s_if.gnt = tbl[i].sg;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), m0_if.gnt, tbl[i].eg0);
            chk($sformatf("tbl%0d_gnt1", i), m1_if.gnt, tbl[i].eg1);
            chk($sformatf("tbl%0d_sreq", i), s_if.req, tbl[i].esreq);
            chk($sformatf("tbl%0d_rvalid0", i), m0_if.rvalid, tbl[i].erv0);
            chk($sformatf("tbl%0d_rvalid1", i), m1_if.rvalid, tbl[i].erv1);
            chk($sformatf("tbl%0d_err0", i), m0_if.rvalid & m0_if.err, tbl[i].eerr0);
            chk($sformatf("tbl%0d_err1", i), m1_if.rvalid & m1_if.err, tbl[i].eerr1);
            next_cycle();
        end

        // Write-then-read with partial byte enables.
        do_reset();
        set_m(1, 1'b1, 32'h8000_0100, 1'b1, 4'b0011, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("wr_gnt1", m1_if.gnt, 1'b1);
        chk("wr_swdata", s_if.wdata, 32'hA5A5_5A5A);
        next_cycle();
        idle();
        set_m(0, 1'b1, 32'h8000_0100, 1'b0, 4'hF, '0);
        @(negedge clk);
        chk("rd_gnt0", m0_if.gnt, 1'b1);
        chk("wr_rvalid1", m1_if.rvalid, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rd_rvalid0", m0_if.rvalid, 1'b1);
        chk("rd_rdata0", m0_if.rdata, 32'h0000_5A5A);
        chk("rd_rdata1_quiet", m1_if.rdata, 32'h0);
        next_cycle();

        // Window boundaries: just below base, just past top, last legal word.
        do_reset();
        set_m(0, 1'b1, 32'h7FFF_FFFC, 1'b0, 4'hF, '0);
        @(negedge clk);
        chk("ill_lo_sreq", s_if.req, 1'b0);
        chk("ill_lo_gnt0", m0_if.gnt, 1'b1);
        next_cycle();
        set_m(0, 1'b1, 32'h8000_8000, 1'b1, 4'hF, 32'h1234_5678);
        @(negedge clk);
        chk("ill_lo_rvalid0", m0_if.rvalid, 1'b1);
        chk("ill_lo_err0", m0_if.err, 1'b1);
        chk("ill_lo_rdata0", m0_if.rdata, 32'hDEAD_BEEF);
        chk("ill_hi_sreq", s_if.req, 1'b0);
        chk("ill_hi_gnt0", m0_if.gnt, 1'b1);
        next_cycle();
        set_m(0, 1'b1, 32'h8000_7FFC, 1'b0, 4'hF, '0);
        @(negedge clk);
        chk("ill_hi_rvalid0", m0_if.rvalid, 1'b1);
        chk("ill_hi_err0", m0_if.err, 1'b1);
        chk("ill_hi_rdata0", m0_if.rdata, 32'hDEAD_BEEF);
        chk("top_sreq", s_if.req, 1'b1);
        chk("top_saddr", s_if.addr, 32'h8000_7FFC);
        next_cycle();
        idle();
        @(negedge clk);
        chk("top_rvalid0", m0_if.rvalid, 1'b1);
        chk("top_err0", m0_if.err, 1'b0);
        next_cycle();

        // Reset right after an m1 grant: its response must never appear.
        do_reset();
        set_m(0, 1'b1, 32'h8000_0000, 1'b0, 4'hF, '0);
        set_m(1, 1'b1, 32'h8000_0004, 1'b0, 4'hF, '0);
        @(negedge clk);
        chk("mid_gnt0", m0_if.gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("mid_gnt1", m1_if.gnt, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rvalid1_in_rst", m1_if.rvalid, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            chk("mid_rvalid1_after", m1_if.rvalid, 1'b0);
            if (m0_if.gnt || m1_if.gnt) begin
                got = 1'b1;
                chk("mid_prio_gnt0", m0_if.gnt, 1'b1);
            end
            next_cycle();
        end
        if (!got) chk("mid_gnt_seen", 1'b0, 1'b1);

        // SRAM stall: no grant, no response, pointer frozen until s_gnt returns.
        do_reset();
        set_m(0, 1'b1, 32'h8000_0008, 1'b0, 4'hF, '0);
        s_if.gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_gnt0", m0_if.gnt, 1'b0);
            chk("stall_sreq", s_if.req, 1'b1);
            chk("stall_rvalid0", m0_if.rvalid, 1'b0);
            next_cycle();
        end
        s_if.gnt = 1'b1;
        @(negedge clk);
        chk("stall_release_gnt0", m0_if.gnt, 1'b1);
        next_cycle();
        set_m(1, 1'b1, 32'h8000_000C, 1'b0, 4'hF, '0);
        @(negedge clk);
        chk("stall_rvalid0_late", m0_if.rvalid, 1'b1);
        chk("stall_rr_gnt1", m1_if.gnt, 1'b1);
        next_cycle();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            set_m(0, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
                  4'($urandom), $urandom);
            set_m(1, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
                  4'($urandom), $urandom);
            s_if.gnt = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_step();
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
